// File: rtl/ascon_ti_pkg.sv
// Shared constants and helpers for the threshold-implementation Ascon datapath.
package ascon_ti_pkg;

    localparam int STATE_W    = 320;
    localparam int WORD_W     = 64;
    localparam int NUM_SHARES = 3;
    localparam int RND_W      = 4;

    localparam int ROT0_A = 19;
    localparam int ROT0_B = 28;
    localparam int ROT1_A = 61;
    localparam int ROT1_B = 39;
    localparam int ROT2_A = 1;
    localparam int ROT2_B = 6;
    localparam int ROT3_A = 10;
    localparam int ROT3_B = 17;
    localparam int ROT4_A = 7;
    localparam int ROT4_B = 41;

    function automatic logic [7:0] ascon_rc(input logic [3:0] j);
        return {4'hF - j, j};
    endfunction

    function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_linear_layer.sv
// Ascon linear diffusion layer on one 320-bit share; purely combinational.
module ascon_linear_layer
    import ascon_ti_pkg::*;
(
    input  logic [STATE_W-1:0] x,
    output logic [STATE_W-1:0] y
);

    logic [WORD_W-1:0] x0, x1, x2, x3, x4;

    assign x0 = x[0*WORD_W +: WORD_W];
    assign x1 = x[1*WORD_W +: WORD_W];
    assign x2 = x[2*WORD_W +: WORD_W];
    assign x3 = x[3*WORD_W +: WORD_W];
    assign x4 = x[4*WORD_W +: WORD_W];

    assign y[0*WORD_W +: WORD_W] = x0 ^ ror64(x0, ROT0_A) ^ ror64(x0, ROT0_B);
    assign y[1*WORD_W +: WORD_W] = x1 ^ ror64(x1, ROT1_A) ^ ror64(x1, ROT1_B);
    assign y[2*WORD_W +: WORD_W] = x2 ^ ror64(x2, ROT2_A) ^ ror64(x2, ROT2_B);
    assign y[3*WORD_W +: WORD_W] = x3 ^ ror64(x3, ROT3_A) ^ ror64(x3, ROT3_B);
    assign y[4*WORD_W +: WORD_W] = x4 ^ ror64(x4, ROT4_A) ^ ror64(x4, ROT4_B);

endmodule

// File: rtl/ascon_ti_diffusion_stage.sv
// Glitch-barrier capture of the TI S-box shares, per-share linear layer, round tracking.
// Optional share refresh at capture is enabled with ASCON_TI_REFRESH_EN.
module ascon_ti_diffusion_stage
    import ascon_ti_pkg::*;
#(
    parameter int ROUNDS = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [STATE_W-1:0] s_sh0,
    input  logic [STATE_W-1:0] s_sh1,
    input  logic [STATE_W-1:0] s_sh2,
`ifdef ASCON_TI_REFRESH_EN
    input  logic [STATE_W-1:0] s_rnd0,
    input  logic [STATE_W-1:0] s_rnd1,
`endif
    output logic               m_valid,
    input  logic               m_ready,
    output logic [STATE_W-1:0] m_sh0,
    output logic [STATE_W-1:0] m_sh1,
    output logic [STATE_W-1:0] m_sh2,
    output logic               m_last,
    output logic [7:0]         rc_next
);

    localparam logic [RND_W-1:0] RND_MAX = 4'(ROUNDS - 1);
    localparam logic [RND_W-1:0] RC_BASE = 4'(12 - ROUNDS);

    logic                                   a_valid_q, a_valid_d;
    logic                                   b_valid_q, b_valid_d;
    logic [NUM_SHARES-1:0][STATE_W-1:0]     a_sh_q, a_sh_d;
    logic [NUM_SHARES-1:0][STATE_W-1:0]     b_sh_q, b_sh_d;
    logic [NUM_SHARES-1:0][STATE_W-1:0]     cap_sh, lin_sh;
    logic [RND_W-1:0]                       rnd_q, rnd_d;
    logic [RND_W-1:0]                       a_rnd_q, a_rnd_d;
    logic [RND_W-1:0]                       b_rnd_q, b_rnd_d;
    logic                                   m_last_q, m_last_d;
    logic                                   a_adv, s_acc;
    logic [RND_W-1:0]                       rc_idx;

`ifdef ASCON_TI_REFRESH_EN
    // Each mask enters exactly two shares, so the unshared value is preserved.
    assign cap_sh[0] = s_sh0 ^ s_rnd0;
    assign cap_sh[1] = s_sh1 ^ s_rnd1;
    assign cap_sh[2] = s_sh2 ^ s_rnd0 ^ s_rnd1;
`else
    assign cap_sh[0] = s_sh0;
    assign cap_sh[1] = s_sh1;
    assign cap_sh[2] = s_sh2;
`endif

    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_lin
        ascon_linear_layer u_lin (
            .x(a_sh_q[i]),
            .y(lin_sh[i])
        );
    end

    assign a_adv   = !b_valid_q || m_ready;
    assign s_ready = !a_valid_q || a_adv;
    assign s_acc   = s_valid && s_ready;

    always_comb begin
        a_valid_d = a_valid_q;
        a_sh_d    = a_sh_q;
        a_rnd_d   = a_rnd_q;
        rnd_d     = rnd_q;
        b_valid_d = b_valid_q;
        b_sh_d    = b_sh_q;
        b_rnd_d   = b_rnd_q;
        m_last_d  = m_last_q;

        if (s_ready) begin
            a_valid_d = s_valid;
        end
        if (s_acc) begin
            a_sh_d  = cap_sh;
            a_rnd_d = rnd_q;
            rnd_d   = (rnd_q == RND_MAX) ? '0 : rnd_q + 4'd1;
        end

        if (a_adv) begin
            b_valid_d = a_valid_q;
            if (a_valid_q) begin
                b_sh_d   = lin_sh;
                b_rnd_d  = a_rnd_q;
                m_last_d = (a_rnd_q == RND_MAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            rnd_q     <= '0;
            a_rnd_q   <= '0;
            b_rnd_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            rnd_q     <= rnd_d;
            a_rnd_q   <= a_rnd_d;
            b_rnd_q   <= b_rnd_d;
            m_last_q  <= m_last_d;
        end
    end

    assign rc_idx  = (b_rnd_q == RND_MAX) ? '0 : b_rnd_q + 4'd1;
    assign rc_next = ascon_rc(RC_BASE + rc_idx);

    assign m_valid = b_valid_q;
    assign m_sh0   = b_sh_q[0];
    assign m_sh1   = b_sh_q[1];
    assign m_sh2   = b_sh_q[2];
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_ascon_ti_diffusion_stage.sv
// Scoreboard bench for ascon_ti_diffusion_stage (ROUNDS=12).
module tb_ascon_ti_diffusion_stage;

    localparam int ROUNDS = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [319:0] s_sh0, s_sh1, s_sh2;
`ifdef ASCON_TI_REFRESH_EN
    logic [319:0] s_rnd0, s_rnd1;
`endif
    logic         m_valid;
    logic         m_ready;
    logic [319:0] m_sh0, m_sh1, m_sh2;
    logic         m_last;
    logic [7:0]   rc_next;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [319:0] x;
        logic [319:0] sh0;
        logic [319:0] sh1;
        logic [319:0] sh2;
        logic         last;
        logic [7:0]   rc;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    m_rnd = 0;

    always #5 clk = ~clk;

    ascon_ti_diffusion_stage #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_sh0(s_sh0), .s_sh1(s_sh1), .s_sh2(s_sh2),
`ifdef ASCON_TI_REFRESH_EN
        .s_rnd0(s_rnd0), .s_rnd1(s_rnd1),
`endif
        .m_valid(m_valid), .m_ready(m_ready),
        .m_sh0(m_sh0), .m_sh1(m_sh1), .m_sh2(m_sh2),
        .m_last(m_last), .rc_next(rc_next)
    );

    // Bit-level reference: rotating right by n means output bit i reads input bit i+n.
    function automatic logic [319:0] model_l(input logic [319:0] x);
        logic [319:0] y;
        int r1 [5];
        int r2 [5];
        r1 = '{19, 61, 1, 10, 17};
        r2 = '{28, 39, 6, 41, 7};
        r2[3] = 17; r1[3] = 10; r2[4] = 41; r1[4] = 7;
        for (int w = 0; w < 5; w++)
            for (int i = 0; i < 64; i++)
                y[64*w + i] = x[64*w + i] ^ x[64*w + (i + r1[w]) % 64] ^ x[64*w + (i + r2[w]) % 64];
        return y;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Handshakes are observed mid-cycle; the transfer happens on the following rising edge.
    always @(negedge clk) begin
        beat_t b;
        int j;
        if (rst) begin
            m_rnd = 0;
        end else begin
            if (m_valid && m_ready) begin
                b.x = '0; b.sh0 = m_sh0; b.sh1 = m_sh1; b.sh2 = m_sh2;
                b.last = m_last; b.rc = rc_next;
                obs_q.push_back(b);
            end
            if (s_valid && s_ready) begin
                b.x = model_l(s_sh0 ^ s_sh1 ^ s_sh2);
`ifdef ASCON_TI_REFRESH_EN
                b.sh0 = model_l(s_sh0 ^ s_rnd0);
                b.sh1 = model_l(s_sh1 ^ s_rnd1);
                b.sh2 = model_l(s_sh2 ^ s_rnd0 ^ s_rnd1);
`else
                b.sh0 = model_l(s_sh0);
                b.sh1 = model_l(s_sh1);
                b.sh2 = model_l(s_sh2);
`endif
                b.last = (m_rnd == ROUNDS - 1);
                j = 12 - ROUNDS + ((m_rnd + 1) % ROUNDS);
                b.rc = {4'(15 - j), 4'(j)};
                m_rnd = (m_rnd + 1) % ROUNDS;
                exp_q.push_back(b);
            end
        end
    end

    task automatic new_data();
        s_sh0 = rand320(); s_sh1 = rand320(); s_sh2 = rand320();
`ifdef ASCON_TI_REFRESH_EN
        s_rnd0 = rand320(); s_rnd1 = rand320();
`endif
    endtask

    task automatic drain(input int budget);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < budget && obs_q.size() < exp_q.size(); c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        m_ready = 1'b0;
        s_sh0 = '0; s_sh1 = '0; s_sh2 = '0;
`ifdef ASCON_TI_REFRESH_EN
        s_rnd0 = '0; s_rnd1 = '0;
`endif
        do_reset();
        tests_run++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ctrl: m_valid=%b m_last=%b s_ready=%b, want 0 0 1", m_valid, m_last, s_ready);
        end
        tests_run++;
        if ((m_sh0 | m_sh1 | m_sh2) !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: m_sh nonzero, m_sh0=%h", m_sh0);
        end
        tests_run++;
        if (rc_next !== 8'hE1) begin
            tests_failed++;
            $display("FAIL reset_rc: rc_next=%h want e1", rc_next);
        end
    endtask

    task automatic test_single();
        beat_t o, e;
        m_ready = 1'b1;
        s_sh0 = '0; s_sh1 = '0; s_sh2 = '0;
        s_sh0[63:0] = 64'h1;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: m_valid=%b one cycle after accept, want 0", m_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (m_valid !== 1'b1 || m_sh0[63:0] !== 64'h0000_2010_0000_0001 || m_sh0[319:64] !== '0 ||
            m_sh1 !== '0 || m_sh2 !== '0 || m_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_beat: m_valid=%b x0=%h last=%b, want 1 0000201000000001 0",
                     m_valid, m_sh0[63:0], m_last);
        end
        drain(10);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests_run++;
            if ((o.sh0 ^ o.sh1 ^ o.sh2) !== e.x || o.last !== e.last || o.rc !== e.rc) begin
                tests_failed++;
                $display("FAIL single_sb: rc=%h last=%b want rc=%h last=%b", o.rc, o.last, e.rc, e.last);
            end
        end
    endtask

    task automatic test_random();
        beat_t o, e;
        int acc_n = 0;
        int mism = 0;
        int share_mism = 0;
        bit acc;
        m_ready = 1'b1;
        new_data();
        s_valid = 1'b1;
        for (int c = 0; c < 5000 && acc_n < 1000; c++) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) acc_n++;
            m_ready = ($urandom_range(0, 3) != 0);
            if (acc || !s_valid) begin
                new_data();
                s_valid = ($urandom_range(0, 4) != 0) && (acc_n < 1000);
            end
        end
        drain(20);
        tests_run++;
        if (obs_q.size() !== 1000 || exp_q.size() !== 1000) begin
            tests_failed++;
            $display("FAIL random_count: got %0d outputs for %0d inputs, want 1000", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ((o.sh0 ^ o.sh1 ^ o.sh2) !== e.x || o.last !== e.last || o.rc !== e.rc) mism++;
            if (o.sh0 !== e.sh0 || o.sh1 !== e.sh1 || o.sh2 !== e.sh2) share_mism++;
        end
        tests_run++;
        if (mism != 0) begin
            tests_failed++;
            $display("FAIL random_invariant: %0d beats wrong, want 0", mism);
        end
        tests_run++;
        if (share_mism != 0) begin
            tests_failed++;
            $display("FAIL random_shares: %0d beats with a wrong share, want 0", share_mism);
        end
    endtask

    task automatic test_rounds();
        beat_t o, e;
        int j;
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            new_data();
            s_valid = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (obs_q.size() !== 12) begin
            tests_failed++;
            $display("FAIL rounds_throughput: %0d beats out two cycles after last input, want 12", obs_q.size());
        end
        drain(10);
        for (int k = 0; k < 12 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            j = (k + 1) % 12;
            tests_run++;
            if (o.last !== (k == 11) || o.rc !== {4'(15 - j), 4'(j)} || (o.sh0 ^ o.sh1 ^ o.sh2) !== e.x) begin
                tests_failed++;
                $display("FAIL rounds_beat%0d: last=%b rc=%h want last=%b rc=%h", k, o.last, o.rc,
                         (k == 11), {4'(15 - j), 4'(j)});
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t o, e;
        int acc_n = 0;
        bit acc;
        bit sr;
        m_ready = 1'b0;
        new_data();
        s_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) begin acc_n++; new_data(); end
        end
        @(negedge clk);
        sr = s_ready;
        tests_run++;
        if (acc_n != 2 || sr !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold: accepted=%0d s_ready=%b, want 2 0", acc_n, sr);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int c = 0; c < 20 && acc_n < 3; c++) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) begin acc_n++; s_valid = (acc_n < 3); end
        end
        drain(10);
        tests_run++;
        if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d outputs for %0d inputs, want 3", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests_run++;
            if ((o.sh0 ^ o.sh1 ^ o.sh2) !== e.x || o.sh0 !== e.sh0 || o.rc !== e.rc || o.last !== e.last) begin
                tests_failed++;
                $display("FAIL bp_order: rc=%h want %h, x0=%h want %h", o.rc, e.rc, o.sh0[63:0], e.sh0[63:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t o, e;
        int acc_n = 0;
        bit acc;
        m_ready = 1'b0;
        new_data();
        s_valid = 1'b1;
        for (int c = 0; c < 10 && acc_n < 2; c++) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) begin acc_n++; new_data(); end
        end
        s_valid = 1'b0;
        tests_run++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_full: m_valid=%b s_ready=%b, want 1 0", m_valid, s_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        tests_run++;
        if (m_valid !== 1'b0 || (m_sh0 | m_sh1 | m_sh2) !== '0 || rc_next !== 8'hE1 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_clear: m_valid=%b rc=%h s_ready=%b, want 0 e1 1", m_valid, rc_next, s_ready);
        end
        m_ready = 1'b1;
        new_data();
        s_valid = 1'b1;
        @(posedge clk); #1;
        drain(10);
        tests_run++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            tests_failed++;
            $display("FAIL rstmid_count: got %0d outputs for %0d inputs, want 1", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests_run++;
            if (o.rc !== 8'hE1 || o.last !== 1'b0 || (o.sh0 ^ o.sh1 ^ o.sh2) !== e.x) begin
                tests_failed++;
                $display("FAIL rstmid_round0: rc=%h last=%b want e1 0", o.rc, o.last);
            end
        end
    endtask

`ifdef ASCON_TI_REFRESH_EN
    task automatic test_refresh();
        beat_t o, e;
        logic [319:0] in0;
        m_ready = 1'b1;
        in0 = rand320();
        s_sh0 = in0; s_sh1 = rand320(); s_sh2 = rand320();
        s_rnd0 = '1; s_rnd1 = '1;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        drain(10);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests_run++;
            if ((o.sh0 ^ o.sh1 ^ o.sh2) !== model_l(in0 ^ s_sh1 ^ s_sh2) || o.sh0 === model_l(in0)) begin
                tests_failed++;
                $display("FAIL refresh: xor x0=%h want %h", (o.sh0 ^ o.sh1 ^ o.sh2) >> 0, e.x[63:0]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_random();
        test_rounds();
        test_backpressure();
        test_reset_mid();
`ifdef ASCON_TI_REFRESH_EN
        test_refresh();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ascon_ti_diffusion_stage.md
# ascon_ti_diffusion_stage

Registered downstream stage of the 3-share threshold-implementation Ascon substitution layer. It captures the three 320-bit output shares of the 64 parallel TI S-boxes in a glitch-barrier register, then applies the Ascon linear diffusion layer independently to each share. It registers the result toward the next round's constant addition. It also tracks the round index and supplies the round constant for the next round.

## Interface
Parameters:
- ROUNDS, 12: rounds per permutation call; legal values 1..12.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  substitution-layer shares valid.
- s_ready  out  1  stage can accept a beat.
- s_sh0, s_sh1, s_sh2  in  320 each  S-box output shares; word x_k = bits [64k+63:64k], k=0..4.
- m_valid  out  1  diffused shares valid.
- m_ready  in  1  consumer accepts.
- m_sh0, m_sh1, m_sh2  out  320 each  diffused shares, same word layout.
- m_last  out  1  beat on m_* is the final round of the permutation.
- rc_next  out  8  round constant for the round following the beat on m_*.
- s_rnd0, s_rnd1  in  320 each  fresh randomness; present only with ASCON_TI_REFRESH_EN.

## Operation
- Two-stage pipeline: stage A (capture register) then stage B (output register). Each stage has its own valid bit.
- Stage A captures s_sh* unmodified. No logic between the inputs and the A register.
- Stage B loads L(A_shi) for each share i. L is a per-word transform:
  - x0 ^= ror(x0,19)^ror(x0,28)
  - x1 ^= ror(x1,61)^ror(x1,39)
  - x2 ^= ror(x2,1)^ror(x2,6)
  - x3 ^= ror(x3,10)^ror(x3,17)
  - x4 ^= ror(x4,7)^ror(x4,41)
- Shares are never combined. Required invariant: m_sh0^m_sh1^m_sh2 = L(s_sh0^s_sh1^s_sh2).
- Round counter rnd, width 4, counts 0..ROUNDS-1. It travels with each beat into stage B.
- m_last = (beat's rnd == ROUNDS-1).
- rc_next = {4'hF-j, j} with j = 12-ROUNDS+((rnd+1) mod ROUNDS).
- rnd increments on each stage-A acceptance. It wraps to 0 after ROUNDS-1.

## Timing
- Handshake on each side is standard valid/ready. A transfer occurs when valid and ready are both high in the same cycle. Data must stay stable while valid is high and ready is low.
- s_ready = !A_valid | (!B_valid | m_ready). Equivalently, A can advance.
- Latency from input acceptance to m_valid is 2 cycles. Throughput is 1 beat per cycle when m_ready stays high.
- Back-pressure: with m_ready low, B holds. A holds once full. s_ready falls, and the stage holds at most 2 beats.
- Simultaneous accept and emit when both stages are full and m_ready is high: A→B and input→A in the same cycle. No bubble.
- Reset values:
  - A_valid, B_valid, m_valid = 0
  - m_sh* = 0
  - m_last = 0
  - rnd = 0
  - rc_next = constant for j = 12-ROUNDS+1 (mod-wrapped as above)
  - s_ready = 1 in the cycle after reset.
- Reset mid-operation discards in-flight beats and zeroes the counter.

## Configuration
- ASCON_TI_REFRESH_EN defined: stage A captures refreshed shares:
  - s_sh0^s_rnd0
  - s_sh1^s_rnd1
  - s_sh2^s_rnd0^s_rnd1

  The unshared value is unchanged. s_rnd* is sampled only on acceptance.
- ASCON_TI_REFRESH_EN undefined: s_rnd* ports are absent and stage A captures the inputs directly.

## Structure
- Shared package ascon_ti_pkg holds:
  - STATE_W=320 and WORD_W=64
  - the rotation-amount constants ROT0_A..ROT4_B
  - function ascon_rc(j) returning the 8-bit constant.
- One sub-module ascon_linear_layer: purely combinational 320→320 L, instantiated three times (one per share).

## Test plan
- Single beat with s_sh0 = x0=64'h1 (all other words and shares 0) and m_ready=1 -> after 2 cycles m_sh0 x0 = 64'h0000_2010_0000_0001, m_sh1=m_sh2=0, m_last=0.
- Random shares (1000 beats) -> XOR of m_sh* equals L(XOR of s_sh*) every beat. No share output depends on the other shares.
- ROUNDS=12, 12 back-to-back beats -> m_last high only on beat 12. rc_next sequence runs 8'hE1, 8'hD2, …, 8'h4B, 8'hF0.
- Hold m_ready low for 5 cycles after 3 offered beats -> exactly 2 accepted and s_ready=0. On release, beats emerge in order with no loss or duplication.
- Assert rst with both stages full -> next cycle m_valid=0, m_sh*=0, rnd=0. The next beat reports round 0.
- With ASCON_TI_REFRESH_EN, s_rnd0=s_rnd1=all-ones -> individual shares change, and the XOR of m_sh* is identical to the non-refresh result.
